// File: rtl/seven_seg_display_ctrl.sv
// N-digit seven-segment controller: hex or double-dabble decimal rendering,
// leading-zero blanking, overflow dashes and per-digit blink.
module seven_seg_display_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int DATA_W     = 32,
   parameter int BLINK_DIV  = 25_000_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [DATA_W-1:0]       i_value,
   input  logic                    i_mode,
   input  logic                    i_blank_lz,
   input  logic [NUM_DIGITS-1:0]   i_blink_mask,
   output logic [7*NUM_DIGITS-1:0] o_seven,
   output logic                    o_overflow
);
   localparam int BW = 4 * NUM_DIGITS;
   localparam int SW = 7 * NUM_DIGITS;
   localparam int CW = $clog2(DATA_W + 1);
   localparam int DW = $clog2(BLINK_DIV);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CONV   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]            state;
   logic [DATA_W-1:0]     val_q;
   logic [BW-1:0]         bcd_q;
   logic [BW-1:0]         bcd_adj;
   logic [BW-1:0]         hex_src;
   logic [BW-1:0]         digits;
   logic [CW-1:0]         bit_cnt;
   logic                  mode_q;
   logic                  blank_q;
   logic                  ovf_acc;
   logic                  hex_ovf;
   logic [SW-1:0]         seg_q;
   logic [SW-1:0]         seg_nxt;
   logic [SW-1:0]         lit;
   logic                  ovf_q;
   logic [NUM_DIGITS-1:0] mask_q;
   logic [DW-1:0]         blink_cnt;
   logic                  phase;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0:    glyph = 7'h3F;
         4'h1:    glyph = 7'h06;
         4'h2:    glyph = 7'h5B;
         4'h3:    glyph = 7'h4F;
         4'h4:    glyph = 7'h66;
         4'h5:    glyph = 7'h6D;
         4'h6:    glyph = 7'h7D;
         4'h7:    glyph = 7'h07;
         4'h8:    glyph = 7'h7F;
         4'h9:    glyph = 7'h6F;
         4'hA:    glyph = 7'h77;
         4'hB:    glyph = 7'h7C;
         4'hC:    glyph = 7'h39;
         4'hD:    glyph = 7'h5E;
         4'hE:    glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   generate
      if (DATA_W > BW) begin : g_wide
         assign hex_ovf = |i_value[DATA_W-1:BW];
         assign hex_src = val_q[BW-1:0];
      end else if (DATA_W == BW) begin : g_eq
         assign hex_ovf = 1'b0;
         assign hex_src = val_q;
      end else begin : g_narrow
         assign hex_ovf = 1'b0;
         assign hex_src = {{(BW-DATA_W){1'b0}}, val_q};
      end
   endgenerate

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_q[4*k+:4] >= 4'd5)
            bcd_adj[4*k+:4] = bcd_q[4*k+:4] + 4'd3;
      end
   end

   assign digits = mode_q ? bcd_q : hex_src;

   // Walk from the top digit down; blank until the first nonzero nibble.
   always_comb begin
      logic       seen;
      logic [3:0] nib;
      logic [6:0] g;
      seen    = 1'b0;
      nib     = 4'h0;
      g       = 7'h00;
      seg_nxt = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nib = digits[4*k+:4];
         g   = ovf_acc ? 7'h40 : glyph(nib);
         if (nib != 4'h0)
            seen = 1'b1;
         if (blank_q && !seen && k != 0)
            g = 7'h00;
         seg_nxt[7*k+:7] = g;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         val_q   <= '0;
         bcd_q   <= '0;
         bit_cnt <= '0;
         mode_q  <= 1'b0;
         blank_q <= 1'b0;
         ovf_acc <= 1'b0;
         seg_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  val_q   <= i_value;
                  mode_q  <= i_mode;
                  blank_q <= i_blank_lz;
                  bcd_q   <= '0;
                  bit_cnt <= '0;
                  ovf_acc <= i_mode ? 1'b0 : hex_ovf;
                  state   <= i_mode ? S_CONV : S_COMMIT;
               end
            end
            S_CONV: begin
               bcd_q   <= {bcd_adj[BW-2:0], val_q[DATA_W-1]};
               val_q   <= val_q << 1;
               bit_cnt <= bit_cnt + 1'b1;
               if (bcd_adj[BW-1])
                  ovf_acc <= 1'b1;
               if (bit_cnt == CW'(DATA_W - 1))
                  state <= S_COMMIT;
            end
            S_COMMIT: begin
               seg_q <= seg_nxt;
               ovf_q <= ovf_acc;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
         mask_q    <= '0;
      end else begin
         mask_q <= i_blink_mask;
         if (blink_cnt == DW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      lit = seg_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (phase && mask_q[k])
            lit[7*k+:7] = 7'h00;
      end
   end

   assign o_seven    = ACTIVE_LOW ? ~lit : lit;
   assign o_overflow = ovf_q;
   assign o_ready    = (state == S_IDLE);

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Bench for seven_seg_display_ctrl: vector table, scoreboard queue,
// and sequences for ignored input, mid-conversion reset and blink.
module tb_seven_seg_display_ctrl;
   localparam int ND = 8;
   localparam int DW = 32;
   localparam int BD = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic          mode  = 1'b0;
   logic          blank = 1'b0;
   logic [DW-1:0] value = '0;
   logic [ND-1:0] mask  = '0;
   logic          ready;
   logic          ovf;
   logic [7*ND-1:0] seven;

   always #5 clk = ~clk;

   seven_seg_display_ctrl #(
      .NUM_DIGITS(ND),
      .DATA_W    (DW),
      .BLINK_DIV (BD),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_value     (value),
      .i_mode      (mode),
      .i_blank_lz  (blank),
      .i_blink_mask(mask),
      .o_seven     (seven),
      .o_overflow  (ovf)
   );

   typedef struct {
      logic [31:0] value;
      logic        mode;
      logic        blank;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [55:0] seven;
      logic        ovf;
      int          lat;
   } exp_t;

   vec_t        tbl[10];
   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [55:0] cur_img;
   logic        cur_ovf;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   function automatic logic [55:0] model(input logic [31:0] v, input logic m,
                                         input logic b, input logic o);
      logic [3:0]  d [8];
      logic [31:0] t;
      logic [6:0]  g;
      logic [55:0] r;
      int          msd;
      t   = v;
      msd = 0;
      for (int k = 0; k < 8; k++) begin
         if (m) begin
            d[k] = 4'(t % 10);
            t    = t / 10;
         end else begin
            d[k] = v[4*k+:4];
         end
         if (d[k] != 4'h0) msd = k;
      end
      for (int k = 0; k < 8; k++) begin
         g = o ? 7'h40 : seg_of(d[k]);
         if (b && k > msd) g = 7'h00;
         r[7*k+:7] = ~g;
      end
      return r;
   endfunction

   task automatic xfer(input logic [31:0] v, input logic m, input logic b,
                       input logic o, input logic inject);
      exp_t e;
      int   n;
      e.seven = model(v, m, b, o);
      e.ovf   = o;
      e.lat   = m ? DW + 1 : 1;
      sb.push_back(e);
      @(negedge clk);
      value = v;
      mode  = m;
      blank = b;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      check("ready_drop", 64'(ready), 64'(1'b0));
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         if (n == 10 && m) begin
            check("held_img", 64'(seven), 64'(cur_img));
            check("held_ovf", 64'(ovf), 64'(cur_ovf));
         end
         if (inject && n == 5) begin
            value = 32'h0000FFFF;
            mode  = 1'b0;
            valid = 1'b1;
         end
         @(posedge clk);
         #1;
         valid = 1'b0;
         n++;
      end
      e = sb.pop_front();
      check("latency", 64'(n), 64'(e.lat));
      check("seven", 64'(seven), 64'(e.seven));
      check("overflow", 64'(ovf), 64'(e.ovf));
      cur_img = e.seven;
      cur_ovf = e.ovf;
      if (inject) begin
         repeat (3) @(posedge clk);
         #1;
         check("no_queue_ready", 64'(ready), 64'(1'b1));
         check("no_queue_img", 64'(seven), 64'(e.seven));
      end
   endtask

   initial begin
      int last;
      int trans;
      logic prev_lit;
      logic now_lit;

      tbl[0] = '{32'h0123ABCD, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{32'd12345678, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{32'd100000000, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{32'h00000005, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{32'd0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{32'd99999999, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
      tbl[8] = '{32'h00000000, 1'b0, 1'b1, 1'b0};
      tbl[9] = '{32'd1000, 1'b1, 1'b1, 1'b0};

      #12;
      check("rst_ready", 64'(ready), 64'(1'b1));
      check("rst_ovf", 64'(ovf), 64'(1'b0));
      check("rst_seven", 64'(seven), 64'({56{1'b1}}));
      @(negedge clk);
      rst_n   = 1'b1;
      cur_img = {56{1'b1}};
      cur_ovf = 1'b0;

      for (int i = 0; i < 10; i++)
         xfer(tbl[i].value, tbl[i].mode, tbl[i].blank, tbl[i].ovf, 1'b0);

      xfer(32'd12345678, 1'b1, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      value = 32'd55555555;
      mode  = 1'b1;
      blank = 1'b0;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midconv_busy", 64'(ready), 64'(1'b0));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 64'(ready), 64'(1'b1));
      check("midrst_ovf", 64'(ovf), 64'(1'b0));
      check("midrst_seven", 64'(seven), 64'({56{1'b1}}));
      @(negedge clk);
      rst_n   = 1'b1;
      cur_img = {56{1'b1}};
      cur_ovf = 1'b0;
      xfer(32'd87654321, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      mask = 8'h01;
      @(posedge clk);
      #1;
      prev_lit = (seven[6:0] === cur_img[6:0]);
      last     = -1;
      trans    = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         check("blink_others", 64'(seven[55:7]), 64'(cur_img[55:7]));
         now_lit = (seven[6:0] === cur_img[6:0]);
         if (!now_lit)
            check("blink_off", 64'(seven[6:0]), 64'(7'h7F));
         if (now_lit != prev_lit) begin
            if (last >= 0)
               check("blink_run", 64'(i - last), 64'(BD));
            last = i;
            trans++;
         end
         prev_lit = now_lit;
      end
      check("blink_toggles", 64'(trans >= 8), 64'(1'b1));

      @(negedge clk);
      mask = 8'h00;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         check("unblink", 64'(seven), 64'(cur_img));
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
